mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the MIPS32 datapath, in the execute stage beside the ALU. It takes the two register-file read operands (rs, rt) and performs MULT/MULTU/DIV/DIVU over multiple cycles, plus single-cycle MTHI/MTLO. It holds the architectural HI/LO registers, whose values feed the write-back mux for MFHI/MFLO into the general register file. It exports `busy` so the hazard unit can stall dependent instructions.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  operation request, sampled each rising edge.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6, 7 reserved (no-op).
- `rs_data`  in  32  operand A (multiplicand/dividend, or MTHI/MTLO source).
- `rt_data`  in  32  operand B (multiplier/divisor).
- `busy`  out  1  high while a multi-cycle operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. Down-counter `cnt` holds the remaining busy cycles.
- IDLE with `start` = 1:
  - Ops 0–3: compute the result from the sampled operands and latch it into pending registers. Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - Op 4 (MTHI): `hi <= rs_data`. Stay in IDLE.
  - Op 5 (MTLO): `lo <= rs_data`. Stay in IDLE.
  - Ops 6, 7: ignored.
- RUN: decrement `cnt` each cycle. On the edge where `cnt` reaches 0, commit the pending values to `hi`/`lo` and return to IDLE.
- `start` while in RUN: ignored entirely (no queueing, no HI/LO change). The hazard unit guarantees it never occurs; the RTL still tolerates it.
- Arithmetic:
  - MULT: 64-bit signed product; `hi` gets bits 63:32, `lo` gets bits 31:0.
  - MULTU: same, unsigned.
  - DIV: `lo` = quotient truncated toward zero; `hi` = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
  - Divide by zero (DIV or DIVU): full busy period still runs; `hi`/`lo` are left unchanged at commit.
- `reset` has priority over everything: state → IDLE, `cnt` → 0, `busy` → 0, `hi` → 0, `lo` → 0. An in-flight operation is discarded.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0.
- `start` sampled at edge k (ops 0–3):
  - `busy` = 1 for exactly N cycles, k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES).
  - `hi`/`lo` change at edge k+N, the same edge `busy` falls; they are valid in the first cycle `busy` = 0.
  - A new `start` is accepted at edge k+N+1 at the earliest (the first edge sampled with `busy` = 0).
- MTHI/MTLO at edge k: the register is updated after edge k (1-cycle latency); `busy` stays 0.
- `busy` is registered. The hazard unit stalls MFHI/MFLO/MTHI/MTLO/mult/div when `busy | start`.
- `hi`/`lo` are stable at all times except at commit, MTHI/MTLO, or reset.

## Structure
- Shared package (`mips_pkg`) holds the MDU op encodings (`MDU_MULT` … `MDU_MTLO`) and the default latency constants. The decoder and hazard unit use the same names.
- Single module; no sub-module. Arithmetic is behavioural (`*`, `/`, `%` on sign-extended or zero-extended 33/64-bit operands), and the latency is modelled only by the counter.

## Test plan
- MULT, rs = 0xFFFFFFFE (−2), rt = 3 → `busy` high for 5 cycles; then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
- MULTU, rs = 0xFFFFFFFF, rt = 0xFFFFFFFF → after 5 cycles `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- DIV, rs = 0xFFFFFFF9 (−7), rt = 2 → `busy` high for 10 cycles; `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then DIVU, rs = 7, rt = 0 → after 10 cycles `hi`/`lo` unchanged.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → each register updates one cycle after its `start`; `busy` never rises. MTLO issued during a DIV busy period → ignored.
- Reset at cycle 3 of a MULT → next cycle `busy` = 0, `hi` = `lo` = 0; the product is never committed. Back-to-back MULT issued at the first non-busy edge → accepted.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MDU op encodings and default latencies for decoder, hazard unit and mdu
package mips_pkg;
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle MIPS32 multiply/divide unit holding the architectural HI/LO registers
module mdu
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;
  logic state;
  logic [CW-1:0] cnt;
  logic [63:0] ax, bx, prod;
  logic signed [32:0] a33, b33;
  logic [31:0] quo, rem, hi_d, lo_d, pend_hi, pend_lo;
  logic is_md, is_div, pend_we;
  // op[0] selects unsigned; extending to 64/33 bits lets one operator serve both signednesses
  always_comb begin
    is_md  = ~op[2];
    is_div = op[1];
    ax     = op[0] ? {32'b0, rs_data} : {{32{rs_data[31]}}, rs_data};
    bx     = op[0] ? {32'b0, rt_data} : {{32{rt_data[31]}}, rt_data};
    prod   = ax * bx;
    a33    = $signed({~op[0] & rs_data[31], rs_data});
    b33    = $signed({~op[0] & rt_data[31], rt_data});
    quo    = 32'(a33 / b33);
    rem    = 32'(a33 % b33);
    hi_d   = is_div ? rem : prod[63:32];
    lo_d   = is_div ? quo : prod[31:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start && is_md) begin
        state   <= S_RUN;
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        pend_hi <= hi_d;
        pend_lo <= lo_d;
        pend_we <= !(is_div && rt_data == 32'd0);
      end else if (start && op == MDU_MTHI) begin
        hi <= rs_data;
      end else if (start && op == MDU_MTLO) begin
        lo <= rs_data;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= S_IDLE;
        if (pend_we) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end
  assign busy = state == S_RUN;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed checks of mdu latency, arithmetic, MTHI/MTLO and reset behaviour
module tb_mdu;
  logic clk = 1'b0;
  logic reset, start, busy;
  logic [2:0] op;
  logic [31:0] rs_data, rt_data, hi, lo;
  int checks = 0;
  int errors = 0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 3'd0;
    rs_data = '0;
    rt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_done("mult_busy", 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_b2b_busy", 5);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div_busy", 10);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);

    issue(3'd3, 32'd7, 32'd0);
    wait_done("divu0_busy", 10);
    check("divu0_hi", hi, 32'hFFFFFFFF);
    check("divu0_lo", lo, 32'hFFFFFFFD);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divovf_busy", 10);
    check("divovf_hi", hi, 32'h0);
    check("divovf_lo", lo, 32'h80000000);

    start = 1'b1;
    op = 3'd4;
    rs_data = 32'h12345678;
    @(posedge clk);
    #1 op = 3'd5;
    rs_data = 32'h9ABCDEF0;
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'h80000000);
    check("mthi_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", 32'(busy), 32'd0);

    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    check("mtlo_in_run_lo", lo, 32'h9ABCDEF0);
    wait_done("divu_rest_busy", 8);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);

    issue(3'd0, 32'd7, 32'd6);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_hi", hi, 32'h0);
    check("rst_run_lo", lo, 32'h0);
    repeat (8) @(negedge clk);
    check("rst_nocommit_lo", lo, 32'h0);

    issue(3'd6, 32'h55555555, 32'd1);
    @(negedge clk);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_hi", hi, 32'h0);
    check("rsvd_lo", lo, 32'h0);

    issue(3'd0, 32'h00010000, 32'hFFFF0000);
    wait_done("mult_neg_busy", 5);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
